ram_w_store_unit: RTL
=====================

# ram_w_store_unit

Store-side counterpart of the RAM read-data extender: accepts CPU store requests (address, value, size) and turns them into byte-lane-masked, byte-swapped RAM writes. Requests are held in a 2-entry store buffer with a valid/ready handshake on both sides. The unit sits between the memory stage and the data RAM write port. It also flags loads that hit a pending store.

## Interface
- `DEPTH`, 2, store buffer entries; power of two, minimum 2.
- `AW`, 32, address width in bits.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `st_valid_i`  in  1  store request valid.
- `st_ready_o`  out  1  buffer can accept a request.
- `st_addr_i`  in  AW  byte address.
- `st_data_i`  in  32  store value, right-justified, little-endian.
- `st_size_i`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `st_fault_o`  out  1  one-cycle pulse when an accepted request is rejected.
- `ram_w_en_o`  out  1  write request valid (head entry present).
- `ram_w_ready_i`  in  1  RAM takes the write this cycle.
- `ram_w_addr_o`  out  AW  word address, low two bits always 0.
- `ram_w_data_o`  out  32  lane-arranged write data.
- `ram_w_mask_o`  out  4  byte-lane write mask.
- `ld_addr_i`  in  AW  address of the load now in the memory stage.
- `st_pend_hit_o`  out  1  a buffered store targets the same word as `ld_addr_i`.
- `st_empty_o`  out  1  buffer empty.

## Operation
- Lane map: byte offset k (`addr[1:0]`) uses mask bit 3-k and data lane [31-8k:24-8k].
- Byte: mask one-hot per offset (00→1000, 01→0100, 10→0010, 11→0001). `st_data_i[7:0]` goes into that lane.
- Halfword: offset 00→1100, with `[31:24]=s[7:0]` and `[23:16]=s[15:8]`. Offset 10→0011, with `[15:8]=s[7:0]` and `[7:0]=s[15:8]`.
- Word: mask 1111, data `{s[7:0],s[15:8],s[23:16],s[31:24]}`.
- Unmasked lanes are driven 0.
- Misaligned means a halfword at an odd offset or a word at a nonzero offset. Size 11 is always rejected.
- Accept when `st_valid_i && st_ready_o`:
  - If the request is legal, it is encoded and pushed at the tail.
  - If it is rejected, nothing is pushed and `st_fault_o` pulses.
- The head entry drives `ram_w_*`. It pops on `ram_w_en_o && ram_w_ready_i`.
- Writes retire strictly in order. Held outputs stay stable until popped.
- `st_pend_hit_o` is combinational: OR over valid entries of `entry_addr[AW-1:2] == ld_addr_i[AW-1:2]`. It is 0 when the buffer is empty.

## Timing
- Reset values:
  - count 0, `st_ready_o` 0 while `rst` is high, then 1.
  - `ram_w_en_o` 0, `ram_w_addr_o` 0, `ram_w_data_o` 0, `ram_w_mask_o` 0.
  - `st_fault_o` 0, `st_pend_hit_o` 0, `st_empty_o` 1.
- Latency: a request accepted in cycle N into an empty buffer shows `ram_w_en_o`=1 in cycle N+1. A fault pulse is also at N+1.
- `st_ready_o = !full`, registered state only. There is no combinational path from `ram_w_ready_i`.
  - When full, a same-cycle pop does not admit a push.
  - When not full, push and pop in the same cycle are both performed and count is unchanged.
- Pointers wrap modulo `DEPTH`.
- A push in the same cycle is not visible to `st_pend_hit_o` until N+1.
- Reset mid-operation discards all entries. No write is issued afterwards.
- `ram_w_ready_i` is ignored while `ram_w_en_o`=0.

## Configuration
- `RAM_W_MISALIGN_CHK_EN` defined:
  - Misaligned and size-11 requests are dropped, and `st_fault_o` pulses.
- Undefined:
  - Misaligned requests are aligned down: a halfword clears `addr[0]`, a word clears `addr[1:0]`. They are then written normally.
  - Size 11 is dropped silently.
  - `st_fault_o` is tied to 0.

## Structure
- Shared package `ram_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - mask constants `MASK_W`, `MASK_H0`, `MASK_H2`;
  - the entry struct (addr, data, mask).
- Sub-module `ram_w_data_align`: combinational lane/mask encoder (size, offset, value → data, mask, misaligned). The top level holds the FIFO, handshake and hit logic.

## Test plan
- Word at 0x100, value 0x11223344 → next cycle `ram_w_en_o`=1, addr 0x100, data 0x44332211, mask 1111.
- Halfword 0xBEEF at 0x202, then byte 0x5A at 0x203 → two writes in order: (0x200, 0x0000EFBE, 0011), then (0x200, 0x0000005A, 0001).
- Two stores pushed with `ram_w_ready_i`=0 → `st_ready_o`=0. A third `st_valid_i` is not accepted. Raising `ram_w_ready_i` for 1 cycle → `st_ready_o`=1 the following cycle.
- Word at 0x101 with macro on → `st_fault_o` pulse, no RAM write. With macro off → write at 0x100, mask 1111.
- Buffered store at 0x304, `ld_addr_i`=0x306 → `st_pend_hit_o`=1. `ld_addr_i`=0x308 → 0.
- `rst` asserted with 2 entries held → `ram_w_en_o`=0 and `st_empty_o`=1 on the next edge, and no further writes.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM store path: size encodings, lane masks and
// the store-buffer entry layout.
package ram_pkg;

    // Widest address an entry can hold; the store unit's AW must not exceed it.
    localparam int RAM_AW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_H0 = 4'b1100;
    localparam logic [3:0] MASK_H2 = 4'b0011;

    // One buffered RAM write: word address, lane-arranged data, lane mask.
    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        mask;
    } entry_t;

    // Byte offset k selects mask bit 3-k.
    function automatic logic [3:0] byte_mask(input logic [1:0] offset);
        return 4'b1000 >> offset;
    endfunction

endpackage

// File: rtl/ram_w_data_align.sv
// Combinational lane encoder: places a right-justified little-endian store
// value into the RAM's byte lanes and produces the matching write mask.
// Misaligned offsets are encoded as if aligned down; the caller decides
// whether such a request is written or dropped.
module ram_w_data_align
    import ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] value,
    output logic [31:0] data,
    output logic [3:0]  mask,
    output logic        misaligned
);

    // Lane/mask selection by access size and byte offset.
    always_comb begin
        data       = '0;
        mask       = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask = byte_mask(offset);
                case (offset)
                    2'd0:    data[31:24] = value[7:0];
                    2'd1:    data[23:16] = value[7:0];
                    2'd2:    data[15:8]  = value[7:0];
                    default: data[7:0]   = value[7:0];
                endcase
            end
            SZ_HALF: begin
                misaligned = offset[0];
                if (!offset[1]) begin
                    data[31:24] = value[7:0];
                    data[23:16] = value[15:8];
                    mask        = MASK_H0;
                end else begin
                    data[15:8] = value[7:0];
                    data[7:0]  = value[15:8];
                    mask       = MASK_H2;
                end
            end
            SZ_WORD: begin
                misaligned = |offset;
                data       = {value[7:0], value[15:8], value[23:16], value[31:24]};
                mask       = MASK_W;
            end
            default: begin
                data = '0;
                mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/ram_w_store_unit.sv
// Store buffer in front of the data RAM write port. Legal store requests are
// lane-encoded and queued in a DEPTH-entry FIFO; the head entry drives the
// RAM write interface. Also reports loads that hit a pending store word.
// Optional feature macro: RAM_W_MISALIGN_CHK_EN (drop misaligned requests and
// pulse st_fault_o instead of aligning them down).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid side holds its payload stable until that edge. On the
// store side st_ready_o depends only on registered state (and rst); on the RAM
// side ram_w_en_o is the valid and ram_w_ready_i the ready.
module ram_w_store_unit
    import ram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid_i,
    output logic          st_ready_o,
    input  logic [AW-1:0] st_addr_i,
    input  logic [31:0]   st_data_i,
    input  logic [1:0]    st_size_i,
    output logic          st_fault_o,
    output logic          ram_w_en_o,
    input  logic          ram_w_ready_i,
    output logic [AW-1:0] ram_w_addr_o,
    output logic [31:0]   ram_w_data_o,
    output logic [3:0]    ram_w_mask_o,
    input  logic [AW-1:0] ld_addr_i,
    output logic          st_pend_hit_o,
    output logic          st_empty_o
);

`ifdef RAM_W_MISALIGN_CHK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic             misaligned;
    logic [31:0]      enc_data;
    logic [3:0]       enc_mask;
    logic [AW-1:0]    hit_addr;
    entry_t           head;

    ram_w_data_align u_align (
        .size       (st_size_i),
        .offset     (st_addr_i[1:0]),
        .value      (st_data_i),
        .data       (enc_data),
        .mask       (enc_mask),
        .misaligned (misaligned)
    );

    assign full       = &vld;
    assign st_ready_o = !full && !rst;
    assign st_empty_o = ~|vld;
    assign accept     = st_valid_i && st_ready_o;
    // Reserved size never writes; misalignment only drops with checking on.
    assign legal      = (st_size_i != SZ_RSVD) && !(MISALIGN_CHK && misaligned);
    assign push       = accept && legal;
    assign head       = mem[rd_ptr];
    assign ram_w_en_o = vld[rd_ptr];
    assign pop        = ram_w_en_o && ram_w_ready_i;

    // Outputs read zero when nothing is pending so idle values match reset.
    assign ram_w_addr_o = ram_w_en_o ? AW'(head.addr) : '0;
    assign ram_w_data_o = ram_w_en_o ? head.data : '0;
    assign ram_w_mask_o = ram_w_en_o ? head.mask : '0;

    // Next occupancy: clear the popped slot, set the pushed slot.
    always_comb begin
        vld_next = vld;
        if (pop) begin
            vld_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            vld_next[wr_ptr] = 1'b1;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            vld <= vld_next;
            if (push) begin
                mem[wr_ptr] <= '{addr: RAM_AW'({st_addr_i[AW-1:2], 2'b00}),
                                 data: enc_data,
                                 mask: enc_mask};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Load/store word-match over registered entries only.
    always_comb begin
        st_pend_hit_o = 1'b0;
        hit_addr      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_addr = AW'(mem[i].addr);
            if (vld[i] && (((hit_addr ^ ld_addr_i) >> 2) == '0)) begin
                st_pend_hit_o = 1'b1;
            end
        end
    end

`ifdef RAM_W_MISALIGN_CHK_EN
    logic fault;

    // One-cycle pulse after an accepted request is rejected.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= accept && !legal;
        end
    end

    assign st_fault_o = fault;
`else
    assign st_fault_o = 1'b0;
`endif

endmodule
